blit_sequencer: RTL and testbench

BLIT_SEQUENCER -- requirements
Module: blit_sequencer

---
 rtl/blit_pkg.sv | 20 ++
 rtl/blit_line_step.sv | 38 +++
 rtl/blit_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_blit_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/blit_pkg.sv
// Shared definitions for the blit sequencer: coordinate width, command opcodes, FSM states.
package blit_pkg;

    localparam int unsigned COORD_W = 16;

    typedef enum logic [1:0] {
        OpRect  = 2'd0,
        OpLine  = 2'd1,
        OpRsvd2 = 2'd2,
        OpRsvd3 = 2'd3
    } blit_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRect = 2'd1,
        StLine = 2'd2,
        StDone = 2'd3
    } blit_state_e;

endpackage

// File: rtl/blit_line_step.sv
// One Bresenham step: next x/y/err from the current point and the line's constant dx/dy/sx/sy.
module blit_line_step
    import blit_pkg::*;
#(
    parameter int unsigned COORD_W = 16
) (
    input  logic        [COORD_W-1:0] x,
    input  logic        [COORD_W-1:0] y,
    input  logic signed [COORD_W+1:0] err,
    input  logic signed [COORD_W+1:0] dx,
    input  logic signed [COORD_W+1:0] dy,
    input  logic                      sx_neg,
    input  logic                      sy_neg,
    output logic        [COORD_W-1:0] x_next,
    output logic        [COORD_W-1:0] y_next,
    output logic signed [COORD_W+1:0] err_next
);

    // |err| <= 2^COORD_W - 1, so doubling it still fits in COORD_W+2 signed bits.
    logic signed [COORD_W+1:0] e2;

    assign e2 = err <<< 1;

    always_comb begin
        x_next   = x;
        y_next   = y;
        err_next = err;
        if (e2 >= dy) begin
            err_next = err_next + dy;
            x_next   = sx_neg ? x - COORD_W'(1) : x + COORD_W'(1);
        end
        if (e2 <= dx) begin
            err_next = err_next + dx;
            y_next   = sy_neg ? y - COORD_W'(1) : y + COORD_W'(1);
        end
    end

endmodule

// File: rtl/blit_sequencer.sv
// Blit sequencer: accepts RECT/LINE commands and emits one pixel coordinate per non-stalled cycle.
module blit_sequencer
    import blit_pkg::*;
#(
    parameter int unsigned COORD_W = 16
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               stall,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [COORD_W-1:0] cmd_x1,
    input  logic [COORD_W-1:0] cmd_y1,
    input  logic [COORD_W-1:0] cmd_x2,
    input  logic [COORD_W-1:0] cmd_y2,
    input  logic [COORD_W-1:0] cmd_src_x,
    input  logic [COORD_W-1:0] cmd_src_y,
    output logic [COORD_W-1:0] p2_rect_dest_x,
    output logic [COORD_W-1:0] p2_rect_dest_y,
    output logic [COORD_W-1:0] p2_rect_src_x,
    output logic [COORD_W-1:0] p2_rect_src_y,
    output logic [COORD_W-1:0] p2_line_x,
    output logic [COORD_W-1:0] p2_line_y,
    output logic               p2_run_rect,
    output logic               p2_run_line,
    output logic               busy,
    output logic               done
);

    blit_state_e state_q;
    logic cmd_ready_q, busy_q, done_q, run_rect_q, run_line_q;

    logic [COORD_W-1:0] dest_x_q, dest_y_q, src_x_q, src_y_q;
    logic [COORD_W-1:0] row_dest_x_q, row_src_x_q, width_q, cnt_x_q, cnt_y_q;

    logic        [COORD_W-1:0] line_x_q, line_y_q, end_x_q, end_y_q;
    logic signed [COORD_W+1:0] dx_q, dy_q, err_q;
    logic                      sx_neg_q, sy_neg_q;

    logic        [COORD_W-1:0] cmd_dx_abs, cmd_dy_abs;
    logic signed [COORD_W+1:0] cmd_dx, cmd_dy, cmd_err;
    logic        [COORD_W-1:0] step_x, step_y;
    logic signed [COORD_W+1:0] step_err;

    // Line setup computed straight from the command so the first pixel is ready next cycle.
    always_comb begin
        cmd_dx_abs = (cmd_x2 >= cmd_x1) ? cmd_x2 - cmd_x1 : cmd_x1 - cmd_x2;
        cmd_dy_abs = (cmd_y2 >= cmd_y1) ? cmd_y2 - cmd_y1 : cmd_y1 - cmd_y2;
        cmd_dx     = $signed({2'b00, cmd_dx_abs});
        cmd_dy     = -$signed({2'b00, cmd_dy_abs});
        cmd_err    = cmd_dx + cmd_dy;
    end

    blit_line_step #(
        .COORD_W(COORD_W)
    ) u_line_step (
        .x       (line_x_q),
        .y       (line_y_q),
        .err     (err_q),
        .dx      (dx_q),
        .dy      (dy_q),
        .sx_neg  (sx_neg_q),
        .sy_neg  (sy_neg_q),
        .x_next  (step_x),
        .y_next  (step_y),
        .err_next(step_err)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            run_rect_q   <= 1'b0;
            run_line_q   <= 1'b0;
            dest_x_q     <= '0;
            dest_y_q     <= '0;
            src_x_q      <= '0;
            src_y_q      <= '0;
            row_dest_x_q <= '0;
            row_src_x_q  <= '0;
            width_q      <= '0;
            cnt_x_q      <= '0;
            cnt_y_q      <= '0;
            line_x_q     <= '0;
            line_y_q     <= '0;
            end_x_q      <= '0;
            end_y_q      <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            err_q        <= '0;
            sx_neg_q     <= 1'b0;
            sy_neg_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        case (blit_op_e'(cmd_op))
                            OpRect: begin
                                if (cmd_x2 == '0 || cmd_y2 == '0) begin
                                    state_q <= StDone;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q      <= StRect;
                                    run_rect_q   <= 1'b1;
                                    dest_x_q     <= cmd_x1;
                                    dest_y_q     <= cmd_y1;
                                    src_x_q      <= cmd_src_x;
                                    src_y_q      <= cmd_src_y;
                                    row_dest_x_q <= cmd_x1;
                                    row_src_x_q  <= cmd_src_x;
                                    width_q      <= cmd_x2;
                                    cnt_x_q      <= cmd_x2;
                                    cnt_y_q      <= cmd_y2;
                                end
                            end
                            OpLine: begin
                                state_q    <= StLine;
                                run_line_q <= 1'b1;
                                line_x_q   <= cmd_x1;
                                line_y_q   <= cmd_y1;
                                end_x_q    <= cmd_x2;
                                end_y_q    <= cmd_y2;
                                dx_q       <= cmd_dx;
                                dy_q       <= cmd_dy;
                                err_q      <= cmd_err;
                                sx_neg_q   <= cmd_x2 < cmd_x1;
                                sy_neg_q   <= cmd_y2 < cmd_y1;
                            end
                            default: begin
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end
                        endcase
                    end
                end
                StRect: begin
                    if (!stall) begin
                        if (cnt_x_q > COORD_W'(1)) begin
                            cnt_x_q  <= cnt_x_q - COORD_W'(1);
                            dest_x_q <= dest_x_q + COORD_W'(1);
                            src_x_q  <= src_x_q + COORD_W'(1);
                        end else if (cnt_y_q > COORD_W'(1)) begin
                            cnt_x_q  <= width_q;
                            cnt_y_q  <= cnt_y_q - COORD_W'(1);
                            dest_x_q <= row_dest_x_q;
                            src_x_q  <= row_src_x_q;
                            dest_y_q <= dest_y_q + COORD_W'(1);
                            src_y_q  <= src_y_q + COORD_W'(1);
                        end else begin
                            state_q    <= StDone;
                            done_q     <= 1'b1;
                            run_rect_q <= 1'b0;
                        end
                    end
                end
                StLine: begin
                    if (!stall) begin
                        if (line_x_q == end_x_q && line_y_q == end_y_q) begin
                            state_q    <= StDone;
                            done_q     <= 1'b1;
                            run_line_q <= 1'b0;
                        end else begin
                            line_x_q <= step_x;
                            line_y_q <= step_y;
                            err_q    <= step_err;
                        end
                    end
                end
                StDone: begin
                    // The done pulse is never stretched by stall.
                    state_q     <= StIdle;
                    done_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign p2_run_rect    = run_rect_q;
    assign p2_run_line    = run_line_q;
    assign p2_rect_dest_x = dest_x_q;
    assign p2_rect_dest_y = dest_y_q;
    assign p2_rect_src_x  = src_x_q;
    assign p2_rect_src_y  = src_y_q;
    assign p2_line_x      = line_x_q;
    assign p2_line_y      = line_y_q;

endmodule

// File: tb/tb_blit_sequencer.sv
// Scoreboard bench for blit_sequencer: directed commands push expected pixels, a monitor pops them.
module tb_blit_sequencer;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        stall = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_x1 = '0, cmd_y1 = '0, cmd_x2 = '0, cmd_y2 = '0;
    logic [15:0] cmd_src_x = '0, cmd_src_y = '0;
    logic [15:0] p2_rect_dest_x, p2_rect_dest_y, p2_rect_src_x, p2_rect_src_y;
    logic [15:0] p2_line_x, p2_line_y;
    logic        p2_run_rect, p2_run_line, busy, done;

    blit_sequencer #(
        .COORD_W(16)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .stall         (stall),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_x1        (cmd_x1),
        .cmd_y1        (cmd_y1),
        .cmd_x2        (cmd_x2),
        .cmd_y2        (cmd_y2),
        .cmd_src_x     (cmd_src_x),
        .cmd_src_y     (cmd_src_y),
        .p2_rect_dest_x(p2_rect_dest_x),
        .p2_rect_dest_y(p2_rect_dest_y),
        .p2_rect_src_x (p2_rect_src_x),
        .p2_rect_src_y (p2_rect_src_y),
        .p2_line_x     (p2_line_x),
        .p2_line_y     (p2_line_y),
        .p2_run_rect   (p2_run_rect),
        .p2_run_line   (p2_run_line),
        .busy          (busy),
        .done          (done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        is_done;
        logic        is_line;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic [15:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    bit   ignore_px = 1'b0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic push_rect(input logic [15:0] dx, dy, sx, sy);
        exp_t e;
        e = '{is_done: 1'b0, is_line: 1'b0, a: dx, b: dy, c: sx, d: sy};
        exp_q.push_back(e);
    endtask

    task automatic push_line(input logic [15:0] x, y);
        exp_t e;
        e = '{is_done: 1'b0, is_line: 1'b1, a: x, b: y, c: 16'h0, d: 16'h0};
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e = '{is_done: 1'b1, is_line: 1'b0, a: 16'h0, b: 16'h0, c: 16'h0, d: 16'h0};
        exp_q.push_back(e);
    endtask

    // Monitor: a pixel shown while stall is low is consumed at the next rising edge.
    logic [95:0] prev_coords = '0;
    bit          prev_stall_run = 1'b0;

    always @(negedge clock) begin
        logic [95:0] cur;
        logic [65:0] act;
        exp_t        e;
        cur = {p2_rect_dest_x, p2_rect_dest_y, p2_rect_src_x, p2_rect_src_y, p2_line_x, p2_line_y};
        if (resetn) begin
            if (p2_run_rect || p2_run_line)
                check("run_exclusive", 96'(p2_run_rect & p2_run_line), 96'(0));
            if (prev_stall_run && (p2_run_rect || p2_run_line))
                check("stall_hold", cur, prev_coords);
            if ((p2_run_rect || p2_run_line) && !stall && !ignore_px) begin
                act = p2_run_line ? {1'b0, 1'b1, p2_line_x, p2_line_y, 32'h0}
                                  : {1'b0, 1'b0, p2_rect_dest_x, p2_rect_dest_y,
                                     p2_rect_src_x, p2_rect_src_y};
                if (exp_q.size() == 0) check("unexpected_pixel", 96'(act), 96'(0));
                else begin
                    e = exp_q.pop_front();
                    check("pixel", 96'(act), 96'(e));
                end
            end
            if (done) begin
                act = {done, p2_run_line, 63'h0, p2_run_rect};
                if (exp_q.size() == 0) check("unexpected_done", 96'(act), 96'(0));
                else begin
                    e = exp_q.pop_front();
                    check("done", 96'(act), 96'(e));
                end
            end
            prev_stall_run = stall && (p2_run_rect || p2_run_line);
            prev_coords    = cur;
        end else begin
            prev_stall_run = 1'b0;
        end
    end

    // Call only from a point #1 after a rising edge.
    task automatic issue(input logic [1:0] op, input logic [15:0] x1, y1, x2, y2, sx, sy);
        int k;
        k = 0;
        while (!cmd_ready && k < 100) begin
            @(posedge clock);
            #1;
            k++;
        end
        if (!cmd_ready) check("ready_timeout", 96'(cmd_ready), 96'(1));
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x1    = x1;
        cmd_y1    = y1;
        cmd_x2    = x2;
        cmd_y2    = y2;
        cmd_src_x = sx;
        cmd_src_y = sy;
        @(posedge clock);
        #1;
        // Scramble the command bus to show it is only sampled at acceptance.
        cmd_valid = 1'b0;
        cmd_op    = 2'd1;
        cmd_x1    = 16'hDEAD;
        cmd_y1    = 16'hBEEF;
        cmd_x2    = 16'h1234;
        cmd_y2    = 16'h5678;
        cmd_src_x = 16'h9ABC;
        cmd_src_y = 16'hDEF0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 300) begin
            @(posedge clock);
            #1;
            k++;
        end
        check(name, 96'(exp_q.size() == 0 && !busy), 96'(1));
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {p2_rect_dest_x, p2_rect_dest_y, p2_rect_src_x, p2_rect_src_y,
                     p2_line_x, p2_line_y}, 96'(0));
        check({name, "_ctl"}, 96'({cmd_ready, busy, done, p2_run_rect, p2_run_line}),
              96'(5'b10000));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset_state");
        resetn = 1'b1;
        @(posedge clock);
        #1;
        check("ready_after_reset", 96'(cmd_ready), 96'(1));

        // RECT 3x2 at (10,20), src (100,5)
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                push_rect(16'(10 + c), 16'(20 + r), 16'(100 + c), 16'(5 + r));
        push_done();
        issue(2'd0, 16'd10, 16'd20, 16'd3, 16'd2, 16'd100, 16'd5);
        wait_idle("rect_3x2");

        // LINE (0,0)->(5,2)
        push_line(0, 0); push_line(1, 0); push_line(2, 1);
        push_line(3, 1); push_line(4, 2); push_line(5, 2);
        push_done();
        issue(2'd1, 16'd0, 16'd0, 16'd5, 16'd2, 16'd0, 16'd0);
        wait_idle("line_shallow");

        // LINE (5,5)->(3,8): negative x step, steep
        push_line(5, 5); push_line(4, 6); push_line(4, 7); push_line(3, 8);
        push_done();
        issue(2'd1, 16'd5, 16'd5, 16'd3, 16'd8, 16'd0, 16'd0);
        wait_idle("line_steep_neg");

        // Single-point LINE
        push_line(3, 3);
        push_done();
        issue(2'd1, 16'd3, 16'd3, 16'd3, 16'd3, 16'd0, 16'd0);
        wait_idle("line_point");

        // Zero-width RECT and reserved op: done pulse only
        push_done();
        issue(2'd0, 16'd7, 16'd7, 16'd0, 16'd4, 16'd1, 16'd1);
        wait_idle("rect_w0");
        push_done();
        issue(2'd3, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6);
        wait_idle("reserved_op");

        // RECT 4x1 with stall over the 2nd and 3rd pixel cycles
        for (int c = 0; c < 4; c++) push_rect(16'(40 + c), 16'd9, 16'(50 + c), 16'd60);
        push_done();
        issue(2'd0, 16'd40, 16'd9, 16'd4, 16'd1, 16'd50, 16'd60);
        @(posedge clock);
        #1;
        stall = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        stall = 1'b0;
        wait_idle("rect_stall");

        // Coordinate wrap
        for (int c = 0; c < 4; c++) push_rect(16'(16'hFFFE + c), 16'd7, 16'(c), 16'd0);
        push_done();
        issue(2'd0, 16'hFFFE, 16'd7, 16'd4, 16'd1, 16'd0, 16'd0);
        wait_idle("rect_wrap");

        // Reset in the middle of a long LINE: no done may follow
        ignore_px = 1'b1;
        issue(2'd1, 16'd0, 16'd0, 16'd30, 16'd0, 16'd0, 16'd0);
        repeat (4) @(posedge clock);
        #1;
        resetn = 1'b0;
        #1;
        check_reset_outputs("mid_line_reset");
        @(posedge clock);
        #1;
        resetn = 1'b1;
        ignore_px = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("idle_after_abort", 96'({cmd_ready, busy}), 96'(2'b10));

        push_line(0, 0); push_line(1, 0); push_line(2, 1);
        push_line(3, 1); push_line(4, 2); push_line(5, 2);
        push_done();
        issue(2'd1, 16'd0, 16'd0, 16'd5, 16'd2, 16'd0, 16'd0);
        wait_idle("line_after_reset");

        repeat (3) @(posedge clock);
        #1;
        check("queue_empty", 96'(exp_q.size()), 96'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
